// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port arbiter in front of a single-port synchronous SRAM.
//
// Each access walks IDLE -> ISSUE -> RESP. The winner is chosen in IDLE and its payload
// is latched on that edge, so later payload changes on the port do not disturb it. ISSUE
// drives the SRAM for exactly one cycle. RESP returns read data and pulses the winner's ack.
//
// Ports:
//   clk, rst                  clock, asynchronous active-low reset
//   p0_req/sel/addr/wdata     port 0 (CPU data side) request; sel == 0 means read
//   p0_ack, p0_stall          port 0 completion pulse, pipeline freeze
//   p1_req/sel/addr/wdata     port 1 (loader/debug side) request
//   p1_ack                    port 1 completion pulse
//   rdata                     read data for the acked port, held between accesses
//   busy                      arbiter is not idle
//   mem_en/we/addr/wdata      SRAM command, valid only during ISSUE
//   mem_rdata                 SRAM read data, one cycle after mem_en
module dmem_arbiter #(
  parameter int unsigned RR_EN = 1,
  parameter int unsigned AW    = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          p0_req,
  input  logic [3:0]    p0_sel,
  input  logic [AW-1:0] p0_addr,
  input  logic [31:0]   p0_wdata,
  output logic          p0_ack,
  output logic          p0_stall,
  input  logic          p1_req,
  input  logic [3:0]    p1_sel,
  input  logic [AW-1:0] p1_addr,
  input  logic [31:0]   p1_wdata,
  output logic          p1_ack,
  output logic [31:0]   rdata,
  output logic          busy,
  output logic          mem_en,
  output logic [3:0]    mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  input  logic [31:0]   mem_rdata
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] RESP  = 2'd2;

  logic [1:0]    state_q, state_d;
  logic          win_q;    // 0 = port 0 owns the access in flight
  logic          last_q;   // port granted most recently
  logic [3:0]    sel_q;
  logic [AW-1:0] addr_q;
  logic [31:0]   wdata_q;
  logic [31:0]   rdata_q;
  logic          any_req;
  logic          grant;
  logic          in_idle, in_issue, in_resp;

  assign any_req  = p0_req | p1_req;
  assign in_idle  = (state_q == IDLE);
  assign in_issue = (state_q == ISSUE);
  assign in_resp  = (state_q == RESP);

  // On a tie, round-robin hands the grant to whichever port did not win last time.
  always_comb begin
    grant = 1'b0;
    if (p0_req && p1_req) begin
      grant = (RR_EN != 0) ? ~last_q : 1'b0;
    end else begin
      grant = p1_req;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = any_req ? ISSUE : IDLE;
      ISSUE:   state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      win_q   <= 1'b0;
      last_q  <= 1'b1;  // port 0 wins the first tie
      sel_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      if (in_idle && any_req) begin
        win_q   <= grant;
        last_q  <= grant;
        sel_q   <= grant ? p1_sel   : p0_sel;
        addr_q  <= grant ? p1_addr  : p0_addr;
        wdata_q <= grant ? p1_wdata : p0_wdata;
      end
      if (in_resp) begin
        rdata_q <= mem_rdata;
      end
    end
  end

  // SRAM command is decoded from registered state so reset withdraws it immediately.
  assign mem_en    = in_issue;
  assign mem_we    = in_issue ? sel_q   : 4'b0000;
  assign mem_addr  = in_issue ? addr_q  : '0;
  assign mem_wdata = in_issue ? wdata_q : 32'h0;

  assign p0_ack   = in_resp & ~win_q;
  assign p1_ack   = in_resp &  win_q;
  assign p0_stall = p0_req & ~p0_ack;
  assign rdata    = in_resp ? mem_rdata : rdata_q;
  assign busy     = ~in_idle;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: DUT 0 is round-robin, DUT 1 is fixed priority. Each has its own
// SRAM model and a transaction-level reference (expected winner, latency, memory contents).
module tb_dmem_arbiter;

  logic        clk;
  logic        rst;
  logic        load;
  logic        req       [2][2];
  logic [3:0]  sel       [2][2];
  logic [31:0] addr      [2][2];
  logic [31:0] wdata     [2][2];
  logic        ack       [2][2];
  logic        stall     [2];
  logic [31:0] rdata     [2];
  logic        busy      [2];
  logic        mem_en    [2];
  logic [3:0]  mem_we    [2];
  logic [31:0] mem_addr  [2];
  logic [31:0] mem_wdata [2];
  logic [31:0] mem_rdata [2];
  logic [31:0] sram      [2][256];

  logic [31:0] ref_mem [2][256];
  int          last_g  [2];
  logic [3:0]  t_sel   [2];
  logic [31:0] t_addr  [2];
  logic [31:0] t_wdata [2];
  int          errs;
  int          checks;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    dmem_arbiter #(
      .RR_EN((g == 0) ? 1 : 0),
      .AW   (32)
    ) u_dut (
      .clk      (clk),
      .rst      (rst),
      .p0_req   (req[g][0]),
      .p0_sel   (sel[g][0]),
      .p0_addr  (addr[g][0]),
      .p0_wdata (wdata[g][0]),
      .p0_ack   (ack[g][0]),
      .p0_stall (stall[g]),
      .p1_req   (req[g][1]),
      .p1_sel   (sel[g][1]),
      .p1_addr  (addr[g][1]),
      .p1_wdata (wdata[g][1]),
      .p1_ack   (ack[g][1]),
      .rdata    (rdata[g]),
      .busy     (busy[g]),
      .mem_en   (mem_en[g]),
      .mem_we   (mem_we[g]),
      .mem_addr (mem_addr[g]),
      .mem_wdata(mem_wdata[g]),
      .mem_rdata(mem_rdata[g])
    );
  end

  function automatic logic [31:0] init_word(input int i);
    if (i == 16) return 32'hDEADBEEF;
    return {8'h5A, 8'(i), 8'(255 - i), 8'(i ^ 8'h3C)};
  endfunction

  // Synchronous SRAM models, one-cycle read latency, byte-masked writes.
  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (load) begin
        for (int i = 0; i < 256; i++) sram[d][i] <= init_word(i);
      end else if (mem_en[d]) begin
        for (int b = 0; b < 4; b++) begin
          if (mem_we[d][b]) sram[d][mem_addr[d][7:0]][b*8 +: 8] <= mem_wdata[d][b*8 +: 8];
        end
        mem_rdata[d] <= sram[d][mem_addr[d][7:0]];
      end
    end
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected winner from the arbitration rules, given which ports are pending.
  function automatic int pick(input int d, input logic [1:0] m);
    if (m == 2'b11) return (d == 0) ? ((last_g[d] == 0) ? 1 : 0) : 0;
    return (m == 2'b10) ? 1 : 0;
  endfunction

  task automatic ref_write(input int d, input int p);
    for (int b = 0; b < 4; b++) begin
      if (t_sel[p][b]) ref_mem[d][t_addr[p][7:0]][b*8 +: 8] = t_wdata[p][b*8 +: 8];
    end
  endtask

  // Raise the ports in mask with the t_* payloads, hold each until served, check everything.
  task automatic run_txn(input int d, input logic [1:0] mask, input string nm);
    int         cyc;
    int         ack_cyc;
    int         w;
    logic [1:0] pend;
    logic [1:0] exp_ack;
    @(negedge clk);
    for (int p = 0; p < 2; p++) begin
      if (mask[p]) begin
        req[d][p] = 1'b1;
        sel[d][p] = t_sel[p];
        addr[d][p] = t_addr[p];
        wdata[d][p] = t_wdata[p];
      end
    end
    pend = mask;
    w = pick(d, pend);
    ack_cyc = 2;
    cyc = 0;
    while (pend != 2'b00 && cyc < 16) begin
      @(negedge clk);
      cyc++;
      exp_ack = 2'b00;
      if (cyc == ack_cyc) exp_ack[w] = 1'b1;
      checks++;
      if ({ack[d][1], ack[d][0]} !== exp_ack) begin
        errs++;
        $display("FAIL %s ack d%0d cyc%0d: got %b want %b", nm, d, cyc,
                 {ack[d][1], ack[d][0]}, exp_ack);
      end
      checks++;
      if (stall[d] !== (pend[0] && !exp_ack[0])) begin
        errs++;
        $display("FAIL %s stall d%0d cyc%0d: got %b want %b", nm, d, cyc, stall[d],
                 pend[0] && !exp_ack[0]);
      end
      if (cyc == ack_cyc - 1) begin
        checks++;
        if ({mem_en[d], mem_we[d], mem_addr[d], mem_wdata[d]} !==
            {1'b1, t_sel[w], t_addr[w], t_wdata[w]}) begin
          errs++;
          $display("FAIL %s issue d%0d: got en=%b we=%h a=%h wd=%h want en=1 we=%h a=%h wd=%h",
                   nm, d, mem_en[d], mem_we[d], mem_addr[d], mem_wdata[d],
                   t_sel[w], t_addr[w], t_wdata[w]);
        end
        // Disturb the live payload; the latched copy must be the one used.
        sel[d][w] = ~t_sel[w];
        addr[d][w] = ~t_addr[w];
        wdata[d][w] = ~t_wdata[w];
      end
      if (cyc == ack_cyc) begin
        if (t_sel[w] == 4'b0000) begin
          checks++;
          if (rdata[d] !== ref_mem[d][t_addr[w][7:0]]) begin
            errs++;
            $display("FAIL %s rdata d%0d p%0d: got %h want %h", nm, d, w, rdata[d],
                     ref_mem[d][t_addr[w][7:0]]);
          end
        end else begin
          ref_write(d, w);
        end
        last_g[d] = w;
        pend[w] = 1'b0;
        req[d][w] = 1'b0;
        if (pend != 2'b00) begin
          w = pick(d, pend);
          ack_cyc += 3;
        end
      end
    end
    if (pend != 2'b00) begin
      checks++;
      errs++;
      $display("FAIL %s timeout d%0d: got pending=%b want 00", nm, d, pend);
    end
    @(negedge clk);
    checks++;
    if ({busy[d], ack[d][1], ack[d][0]} !== 3'b000) begin
      errs++;
      $display("FAIL %s idle d%0d: got busy/acks=%b want 000", nm, d,
               {busy[d], ack[d][1], ack[d][0]});
    end
  endtask

  task automatic test_reset;
    rst = 1'b0;
    load = 1'b1;
    @(posedge clk);
    @(negedge clk);
    load = 1'b0;
    for (int d = 0; d < 2; d++) begin
      checks++;
      if ({busy[d], mem_en[d], mem_we[d], mem_addr[d], mem_wdata[d], rdata[d],
           ack[d][0], ack[d][1]} !== '0) begin
        errs++;
        $display("FAIL reset_outputs d%0d: got busy=%b en=%b we=%h a=%h wd=%h rd=%h want 0",
                 d, busy[d], mem_en[d], mem_we[d], mem_addr[d], mem_wdata[d], rdata[d]);
      end
      req[d][0] = 1'b1;
      #1;
      checks++;
      if (stall[d] !== 1'b1) begin
        errs++;
        $display("FAIL reset_stall_hi d%0d: got %b want 1", d, stall[d]);
      end
      req[d][0] = 1'b0;
      #1;
      checks++;
      if (stall[d] !== 1'b0) begin
        errs++;
        $display("FAIL reset_stall_lo d%0d: got %b want 0", d, stall[d]);
      end
    end
    @(negedge clk);
    rst = 1'b1;
    last_g[0] = 1;
    last_g[1] = 1;
  endtask

  // Both ports held: round-robin alternates, fixed priority starves port 1 until p0 drops.
  task automatic test_contention(input int d);
    int         exp_port [5];
    int         exp_cyc  [5];
    logic [1:0] exp_ack;
    if (d == 0) exp_port = '{0, 1, 0, 1, -1};
    else        exp_port = '{0, 0, 0, 0, 1};
    exp_cyc = '{2, 5, 8, 11, 14};
    @(negedge clk);
    for (int p = 0; p < 2; p++) begin
      req[d][p] = 1'b1;
      sel[d][p] = 4'b0000;
      addr[d][p] = 32'h40 + 32'(p * 4);
      wdata[d][p] = 32'h0;
    end
    for (int cyc = 1; cyc <= 16; cyc++) begin
      @(negedge clk);
      exp_ack = 2'b00;
      for (int i = 0; i < 5; i++) begin
        if (exp_cyc[i] == cyc && exp_port[i] >= 0) exp_ack[exp_port[i]] = 1'b1;
      end
      checks++;
      if ({ack[d][1], ack[d][0]} !== exp_ack) begin
        errs++;
        $display("FAIL contention ack d%0d cyc%0d: got %b want %b", d, cyc,
                 {ack[d][1], ack[d][0]}, exp_ack);
      end
      if (exp_ack != 2'b00) begin
        checks++;
        if (rdata[d] !== ref_mem[d][8'h40 + 8'(exp_ack[1] ? 4 : 0)]) begin
          errs++;
          $display("FAIL contention rdata d%0d cyc%0d: got %h want %h", d, cyc, rdata[d],
                   ref_mem[d][8'h40 + 8'(exp_ack[1] ? 4 : 0)]);
        end
      end
      if (cyc == 11) begin
        req[d][0] = 1'b0;
        if (d == 0) req[d][1] = 1'b0;
      end
      if (cyc == 14) req[d][1] = 1'b0;
    end
    checks++;
    if (busy[d] !== 1'b0) begin
      errs++;
      $display("FAIL contention busy d%0d: got %b want 0", d, busy[d]);
    end
    last_g[d] = 1;
  endtask

  task automatic test_single_read;
    t_sel[0] = 4'b0000;
    t_addr[0] = 32'h10;
    t_wdata[0] = 32'h0;
    run_txn(0, 2'b01, "single_read");
    checks++;
    if (rdata[0] !== 32'hDEADBEEF) begin
      errs++;
      $display("FAIL single_read_hold: got %h want deadbeef", rdata[0]);
    end
  endtask

  task automatic test_byte_write;
    logic [31:0] expw;
    expw = init_word(32);
    expw[15:8] = 8'hAB;
    t_sel[1] = 4'b0010;
    t_addr[1] = 32'h20;
    t_wdata[1] = 32'h0000AB00;
    run_txn(0, 2'b10, "byte_write");
    checks++;
    if (sram[0][32] !== expw) begin
      errs++;
      $display("FAIL byte_write_sram: got %h want %h", sram[0][32], expw);
    end
    t_sel[1] = 4'b0000;
    run_txn(0, 2'b10, "byte_readback");
  endtask

  task automatic test_withdrawn;
    @(negedge clk);
    req[0][0] = 1'b1;
    sel[0][0] = 4'b0000;
    addr[0][0] = 32'h50;
    @(negedge clk);
    req[0][1] = 1'b1;
    sel[0][1] = 4'b1111;
    addr[0][1] = 32'h60;
    wdata[0][1] = 32'hFFFFFFFF;
    @(negedge clk);
    checks++;
    if ({ack[0][1], ack[0][0]} !== 2'b01 || rdata[0] !== ref_mem[0][8'h50]) begin
      errs++;
      $display("FAIL withdrawn_p0: got acks=%b rd=%h want 01 %h", {ack[0][1], ack[0][0]},
               rdata[0], ref_mem[0][8'h50]);
    end
    req[0][0] = 1'b0;
    req[0][1] = 1'b0;
    last_g[0] = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checks++;
      if ({mem_en[0], ack[0][1], ack[0][0]} !== 3'b000) begin
        errs++;
        $display("FAIL withdrawn_quiet cyc%0d: got en/acks=%b want 000", c,
                 {mem_en[0], ack[0][1], ack[0][0]});
      end
    end
    checks++;
    if (sram[0][8'h60] !== ref_mem[0][8'h60]) begin
      errs++;
      $display("FAIL withdrawn_sram: got %h want %h", sram[0][8'h60], ref_mem[0][8'h60]);
    end
  endtask

  task automatic test_reset_mid;
    @(negedge clk);
    req[0][0] = 1'b1;
    sel[0][0] = 4'b1111;
    addr[0][0] = 32'h30;
    wdata[0][0] = 32'h12345678;
    @(negedge clk);
    checks++;
    if (mem_en[0] !== 1'b1) begin
      errs++;
      $display("FAIL reset_mid_issue: got mem_en=%b want 1", mem_en[0]);
    end
    rst = 1'b0;
    #1;
    checks++;
    if ({busy[0], mem_en[0], mem_we[0], mem_addr[0], mem_wdata[0], rdata[0],
         ack[0][0], ack[0][1]} !== '0) begin
      errs++;
      $display("FAIL reset_mid_outputs: got busy=%b en=%b we=%h a=%h wd=%h rd=%h want 0",
               busy[0], mem_en[0], mem_we[0], mem_addr[0], mem_wdata[0], rdata[0]);
    end
    req[0][0] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    last_g[0] = 1;
    last_g[1] = 1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      checks++;
      if ({busy[0], mem_en[0], ack[0][1], ack[0][0]} !== 4'b0000) begin
        errs++;
        $display("FAIL reset_mid_quiet cyc%0d: got %b want 0000", c,
                 {busy[0], mem_en[0], ack[0][1], ack[0][0]});
      end
    end
    checks++;
    if (sram[0][8'h30] !== ref_mem[0][8'h30]) begin
      errs++;
      $display("FAIL reset_mid_sram: got %h want %h", sram[0][8'h30], ref_mem[0][8'h30]);
    end
  endtask

  task automatic test_random;
    logic [1:0] m;
    for (int it = 0; it < 30; it++) begin
      for (int d = 0; d < 2; d++) begin
        for (int p = 0; p < 2; p++) begin
          t_sel[p] = ($urandom_range(1, 0) == 0) ? 4'b0000 : 4'($urandom_range(15, 1));
          t_addr[p] = $urandom;
          t_wdata[p] = $urandom;
        end
        m = 2'($urandom_range(3, 1));
        run_txn(d, m, "random");
      end
    end
  endtask

  initial begin
    errs = 0;
    checks = 0;
    for (int d = 0; d < 2; d++) begin
      last_g[d] = 1;
      for (int i = 0; i < 256; i++) ref_mem[d][i] = init_word(i);
      for (int p = 0; p < 2; p++) begin
        req[d][p] = 1'b0;
        sel[d][p] = 4'b0;
        addr[d][p] = 32'h0;
        wdata[d][p] = 32'h0;
      end
    end
    test_reset();
    test_contention(0);
    test_contention(1);
    test_single_read();
    test_byte_write();
    test_withdrawn();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

endmodule
